// File: rtl/inst_decode_queue.sv
// Registered RISC-V decode stage: decodes fetched words into InstCtrl plus a sign-extended
// immediate and buffers them in a DEPTH-entry FIFO with flush and a saturating decode counter.
package inst_decode_queue_pkg;
  typedef enum logic [2:0] {
    INST_X = 3'd0,
    INST_U = 3'd1,
    INST_J = 3'd2,
    INST_I = 3'd3,
    INST_B = 3'd4,
    INST_S = 3'd5,
    INST_R = 3'd6
  } itype_e;

  typedef struct packed {
    itype_e     itype;
    logic       rwb_en;
    logic       is_lui;
    logic       is_aluop;
    logic       is_muldiv;
    logic       is_op32;
    logic       is_jump;
    logic       is_load;
    logic       is_csr;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } InstCtrl;

  localparam int CTRL_W = $bits(InstCtrl);

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
endpackage

module inst_decode_queue
  import inst_decode_queue_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int DEPTH    = 4,
  parameter bit ENABLE_M = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [XLEN-1:0]          i_pc,
  input  logic [31:0]              i_bits,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [XLEN-1:0]          o_pc,
  output logic [31:0]              o_bits,
  output logic [CTRL_W-1:0]        o_ctrl,
  output logic [XLEN-1:0]          o_imm,
  output logic                     o_illegal,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [CNT_W-1:0]         o_decoded
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [6:0]      opcode;
  logic [6:0]      f7;
  logic [2:0]      f3;
  logic            is_m;
  logic            f7_ok;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  InstCtrl         dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  assign opcode = i_bits[6:0];
  assign f3     = i_bits[14:12];
  assign f7     = i_bits[31:25];
  assign is_m   = (f7 == 7'b0000001);
  assign f7_ok  = (f7 == 7'b0000000) || (f7 == 7'b0100000) || (is_m && ENABLE_M);

  assign imm_i = XLEN'($signed(i_bits[31:20]));
  assign imm_s = XLEN'($signed({i_bits[31:25], i_bits[11:7]}));
  assign imm_b = XLEN'($signed({i_bits[31], i_bits[7], i_bits[30:25], i_bits[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({i_bits[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({i_bits[31], i_bits[19:12], i_bits[20], i_bits[30:21], 1'b0}));

  always_comb begin
    dec_ctrl        = '0;
    dec_ctrl.funct3 = f3;
    dec_ctrl.funct7 = f7;
    dec_imm         = '0;
    dec_illegal     = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_ctrl.itype  = INST_U;
        dec_ctrl.rwb_en = 1'b1;
        dec_ctrl.is_lui = 1'b1;
        dec_imm         = imm_u;
      end
      OPC_AUIPC: begin
        dec_ctrl.itype  = INST_U;
        dec_ctrl.rwb_en = 1'b1;
        dec_imm         = imm_u;
      end
      OPC_JAL: begin
        dec_ctrl.itype   = INST_J;
        dec_ctrl.rwb_en  = 1'b1;
        dec_ctrl.is_jump = 1'b1;
        dec_imm          = imm_j;
      end
      OPC_JALR: begin
        dec_ctrl.itype   = INST_I;
        dec_ctrl.rwb_en  = 1'b1;
        dec_ctrl.is_jump = 1'b1;
        dec_imm          = imm_i;
        if (f3 != 3'b000) dec_illegal = 1'b1;
      end
      OPC_BRANCH: begin
        dec_ctrl.itype = INST_B;
        dec_imm        = imm_b;
      end
      OPC_LOAD: begin
        dec_ctrl.itype   = INST_I;
        dec_ctrl.rwb_en  = 1'b1;
        dec_ctrl.is_load = 1'b1;
        dec_imm          = imm_i;
      end
      OPC_STORE: begin
        dec_ctrl.itype = INST_S;
        dec_imm        = imm_s;
      end
      OPC_OP, OPC_OP_32: begin
        dec_ctrl.itype     = INST_R;
        dec_ctrl.rwb_en    = 1'b1;
        dec_ctrl.is_muldiv = is_m;
        dec_ctrl.is_aluop  = !is_m;
        dec_ctrl.is_op32   = (opcode == OPC_OP_32);
        if (!f7_ok) dec_illegal = 1'b1;
        if (opcode == OPC_OP_32 && XLEN == 32) dec_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_ctrl.itype    = INST_I;
        dec_ctrl.rwb_en   = 1'b1;
        dec_ctrl.is_aluop = 1'b1;
        dec_imm           = imm_i;
        // RV32 shift amounts are 5 bits; shamt[5] set is reserved
        if (XLEN == 32 && (f3 == 3'b001 || f3 == 3'b101) && i_bits[25]) dec_illegal = 1'b1;
      end
      OPC_OP_IMM_32: begin
        dec_ctrl.itype    = INST_I;
        dec_ctrl.rwb_en   = 1'b1;
        dec_ctrl.is_aluop = 1'b1;
        dec_ctrl.is_op32  = 1'b1;
        dec_imm           = imm_i;
        if (XLEN == 32) dec_illegal = 1'b1;
      end
      OPC_SYSTEM: begin
        dec_ctrl.itype  = INST_I;
        dec_ctrl.is_csr = (f3 != 3'b000);
        dec_ctrl.rwb_en = (f3 != 3'b000);
        dec_imm         = imm_i;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (i_bits[1:0] != 2'b11) dec_illegal = 1'b1;
    if (dec_illegal) dec_ctrl = '0;
  end

  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [31:0]     bits_mem[DEPTH];
  InstCtrl         ctrl_mem[DEPTH];
  logic [XLEN-1:0] imm_mem [DEPTH];
  logic            ill_mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] dec_q, dec_d;
  logic             push, pop;

  assign i_ready = (count_q < CW'(DEPTH));
  assign o_valid = (count_q != '0);
  assign push    = i_valid & i_ready;
  assign pop     = o_valid & o_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dec_d    = dec_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push && dec_q != '1) dec_d = dec_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dec_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dec_q    <= dec_d;
    end
  end

  // Payload storage needs no reset: it is only observed while o_valid is high
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr_q]   <= i_pc;
      bits_mem[wr_ptr_q] <= i_bits;
      ctrl_mem[wr_ptr_q] <= dec_ctrl;
      imm_mem[wr_ptr_q]  <= dec_imm;
      ill_mem[wr_ptr_q]  <= dec_illegal;
    end
  end

  assign o_pc      = pc_mem[rd_ptr_q];
  assign o_bits    = bits_mem[rd_ptr_q];
  assign o_ctrl    = ctrl_mem[rd_ptr_q];
  assign o_imm     = imm_mem[rd_ptr_q];
  assign o_illegal = ill_mem[rd_ptr_q];
  assign o_count   = count_q;
  assign o_decoded = dec_q;
endmodule
